// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares the LCD_CTRL command port between a host (A)
// and a script engine (B) using round-robin arbitration.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   a_req/a_cmd/a_gnt   requester A handshake (gnt is a 1-cycle pulse)
//   b_req/b_cmd/b_gnt   requester B handshake (gnt is a 1-cycle pulse)
//   lcd_busy, lcd_done  status inputs from LCD_CTRL
//   cmd, cmd_valid      command and its 1-cycle strobe to LCD_CTRL
//   frozen, seq_done    WRITE drain flag and its completion pulse
//   issued_cnt          saturating count of issued commands
module lcd_cmd_arbiter #(
    parameter int CNT_W  = 8,
    parameter int GUARD  = 1,
    parameter bit PRIO_A = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic [2:0]       a_cmd,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic [2:0]       b_cmd,
    output logic             b_gnt,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic [2:0]       cmd,
    output logic             cmd_valid,
    output logic             frozen,
    output logic             seq_done,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic             rr_q;
    logic [1:0]       guard_q;
    logic             a_gnt_q;
    logic             b_gnt_q;
    logic [2:0]       cmd_q;
    logic             cmd_valid_q;
    logic             frozen_q;
    logic             seq_done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pick_a;

    // rr_q = 1 means A wins a tie.
    assign pick_a = a_req && (!b_req || rr_q);

    assign cnt_d = (cnt_q == {CNT_W{1'b1}})
                 ? cnt_q
                 : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= PRIO_A;
            guard_q     <= 2'd0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
            frozen_q    <= 1'b0;
            seq_done_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!lcd_busy && (a_req || b_req)) begin
                        if (pick_a) begin
                            a_gnt_q <= 1'b1;
                            cmd_q   <= a_cmd;
                        end else begin
                            b_gnt_q <= 1'b1;
                            cmd_q   <= b_cmd;
                        end
                        // Only a real contest hands priority to the loser.
                        if (a_req && b_req) begin
                            rr_q <= ~rr_q;
                        end
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_valid_q <= 1'b1;
                    cnt_q       <= cnt_d;
                    if (cmd_q == 3'd0) begin
                        frozen_q <= 1'b1;
                        state_q  <= S_DRAIN;
                    end else begin
                        guard_q <= 2'(GUARD);
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    // LCD_CTRL needs a cycle or more to raise busy.
                    if (guard_q <= 2'd1) begin
                        state_q <= S_WAIT;
                    end else begin
                        guard_q <= guard_q - 2'd1;
                    end
                end
                S_WAIT: begin
                    if (!lcd_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (lcd_done) begin
                        seq_done_q <= 1'b1;
                        frozen_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign frozen     = frozen_q;
    assign seq_done   = seq_done_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: directed bench for lcd_cmd_arbiter.
// A second instance with a 3-bit counter shares all inputs.
module tb_lcd_cmd_arbiter;

    localparam int GUARD = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, b_req;
    logic [2:0] a_cmd, b_cmd;
    logic       lcd_busy, lcd_done;
    logic       force_busy;
    logic       clr_mon;

    logic       a_gnt, b_gnt, cmd_valid, frozen, seq_done;
    logic [2:0] cmd;
    logic [7:0] issued_cnt;

    logic       a_gnt3, b_gnt3, cmd_valid3, frozen3, seq_done3;
    logic [2:0] cmd3;
    logic [2:0] issued_cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    int last_cv  = -1;
    int min_gap  = 1000;
    int dbl_cnt  = 0;
    int both_cnt = 0;
    logic prev_cv = 1'b0;

    always #5 clk = ~clk;

    lcd_cmd_arbiter #(.CNT_W(8), .GUARD(GUARD), .PRIO_A(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_cmd(a_cmd), .a_gnt(a_gnt),
        .b_req(b_req), .b_cmd(b_cmd), .b_gnt(b_gnt),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .cmd(cmd), .cmd_valid(cmd_valid),
        .frozen(frozen), .seq_done(seq_done),
        .issued_cnt(issued_cnt)
    );

    lcd_cmd_arbiter #(.CNT_W(3), .GUARD(GUARD), .PRIO_A(1'b1)) u_dut3 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_cmd(a_cmd), .a_gnt(a_gnt3),
        .b_req(b_req), .b_cmd(b_cmd), .b_gnt(b_gnt3),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .cmd(cmd3), .cmd_valid(cmd_valid3),
        .frozen(frozen3), .seq_done(seq_done3),
        .issued_cnt(issued_cnt3)
    );

    // LCD model: busy for 4 cycles after each strobe.
    assign lcd_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (reset || clr_mon) begin
            last_cv = -1;
            min_gap = 1000;
            dbl_cnt = 0;
        end else if (cmd_valid) begin
            if (prev_cv) dbl_cnt = dbl_cnt + 1;
            if (last_cv >= 0 && (cyc - last_cv) < min_gap)
                min_gap = cyc - last_cv;
            last_cv = cyc;
        end
        if (a_gnt && b_gnt) both_cnt = both_cnt + 1;
        prev_cv = cmd_valid;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [7:0] w, output int n);
        w = "-";
        n = 0;
        do begin
            step();
            n++;
        end while (!(a_gnt || b_gnt) && n < 40);
        check("gnt_seen", 32'(a_gnt || b_gnt), 1);
        if (a_gnt) w = "A";
        else if (b_gnt) w = "B";
    endtask

    initial begin
        logic [7:0] w;
        int n;
        int bad;

        reset = 1'b1;
        a_req = 0; b_req = 0;
        a_cmd = 0; b_cmd = 0;
        lcd_done = 0; force_busy = 0; clr_mon = 0;
        repeat (3) step();

        check("reset_outs",
              {a_gnt, b_gnt, cmd_valid, frozen, seq_done, cmd}, 0);
        check("reset_cnt", issued_cnt, 0);

        // 1: busy after reset holds off the grant
        reset = 1'b0;
        force_busy = 1'b1;
        a_req = 1; a_cmd = 3'd3;
        bad = 0;
        repeat (20) begin
            step();
            if (a_gnt || b_gnt) bad++;
        end
        check("t1_no_gnt_busy", bad, 0);
        force_busy = 1'b0;
        wait_gnt(w, n);
        check("t1_gnt_A", w, "A");
        check("t1_gnt_lat", n, 1);
        a_req = 0;
        step();
        check("t1_cv", cmd_valid, 1);
        check("t1_cmd", cmd, 3);
        check("t1_cnt", issued_cnt, 1);
        step();
        check("t1_cv_1cyc", cmd_valid, 0);

        // 2: both held, grants alternate
        clr_mon = 1;
        step();
        step();
        clr_mon = 0;
        a_req = 1; a_cmd = 3'd1;
        b_req = 1; b_cmd = 3'd2;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w, n);
            check("t2_order", w, (k % 2 == 0) ? "A" : "B");
            step();
            if (k == 3) begin
                a_req = 0;
                b_req = 0;
            end
            check("t2_cv", cmd_valid, 1);
            check("t2_cmd", cmd, (k % 2 == 0) ? 3'd1 : 3'd2);
        end
        check("t2_min_gap", 32'(min_gap >= GUARD + 3), 1);
        check("t2_dbl_strobe", dbl_cnt, 0);
        check("t2_cnt", issued_cnt, 5);

        // 3: B alone, then A and B contend during WAIT
        repeat (12) step();
        b_req = 1; b_cmd = 3'd5;
        wait_gnt(w, n);
        check("t3_gnt_B", w, "B");
        b_req = 0;
        step();
        check("t3_cmd5", cmd, 5);
        step();
        a_req = 1; a_cmd = 3'd6;
        b_req = 1; b_cmd = 3'd7;
        wait_gnt(w, n);
        check("t3_gnt_A", w, "A");
        a_req = 0;
        step();
        check("t3_cmd6", cmd, 6);
        wait_gnt(w, n);
        check("t3_gnt_B2", w, "B");
        b_req = 0;
        step();
        check("t3_cmd7", cmd, 7);

        // 4: WRITE freezes issue until lcd_done
        repeat (12) step();
        a_req = 1; a_cmd = 3'd0;
        wait_gnt(w, n);
        check("t4_gnt_A", w, "A");
        a_req = 0;
        b_req = 1; b_cmd = 3'd4;
        step();
        check("t4_cv", cmd_valid, 1);
        check("t4_cmd0", cmd, 0);
        check("t4_frozen", frozen, 1);
        bad = 0;
        repeat (30) begin
            step();
            if (a_gnt || b_gnt || !frozen || seq_done) bad++;
        end
        check("t4_held_frozen", bad, 0);
        lcd_done = 1;
        step();
        lcd_done = 0;
        check("t4_seq_done", seq_done, 1);
        check("t4_unfrozen", frozen, 0);
        step();
        check("t4_b_gnt", b_gnt, 1);
        check("t4_seq_done_1cyc", seq_done, 0);
        b_req = 0;
        step();
        check("t4_cmd4", cmd, 4);

        // 5: 3-bit counter saturates
        reset = 1;
        step();
        reset = 0;
        check("t5_cnt3_rst", issued_cnt3, 0);
        a_req = 1; a_cmd = 3'd1;
        for (int k = 0; k < 10; k++) begin
            wait_gnt(w, n);
            step();
            if (k == 6) check("t5_cnt3_at7", issued_cnt3, 7);
        end
        a_req = 0;
        check("t5_cnt3_sat", issued_cnt3, 7);
        check("t5_cnt8", issued_cnt, 10);

        // 6: async reset in GUARD, pointer back to A
        repeat (12) step();
        a_req = 1; a_cmd = 3'd2;
        b_req = 1; b_cmd = 3'd3;
        wait_gnt(w, n);
        check("t6_gnt_A", w, "A");
        a_req = 0;
        b_req = 0;
        step();
        check("t6_cv", cmd_valid, 1);
        #1 reset = 1;
        #1;
        check("t6_rst_outs",
              {a_gnt, b_gnt, cmd_valid, frozen, seq_done, cmd}, 0);
        check("t6_rst_cnt", issued_cnt, 0);
        step();
        reset = 0;
        a_req = 1; a_cmd = 3'd2;
        b_req = 1; b_cmd = 3'd3;
        wait_gnt(w, n);
        check("t6_rr_prio_A", w, "A");
        a_req = 0;
        b_req = 0;
        step();
        check("t6_cmd2", cmd, 2);

        check("never_both_gnt", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
